// File: rtl/dphy_pkg.sv
// Shared D-PHY lane types and constants: sequencer state encoding, HS sync byte,
// and LP line-pair states packed as {lp_p, lp_n}.
package dphy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LP01,
    S_LP00,
    S_HS_ZERO,
    S_HS_SYNC,
    S_HS_DATA,
    S_HS_TRAIL,
    S_HS_EXIT
  } dphy_state_e;

  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dphy_lp_timer.sv
// Load/decrement timing counter with a zero flag; shared by the data- and
// clock-lane sequencers. A load of N-1 yields a zero flag after N cycles.
module dphy_lp_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dphy_data_lane_seq.sv
// MIPI D-PHY data lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS zero/sync/payload/trail -> LP-11.
// Optional burst/underflow statistics counters enabled by defining DPHY_LANE_STATS_EN.
module dphy_data_lane_seq
  import dphy_pkg::*;
#(
  parameter int unsigned T_LPX      = 4,
  parameter int unsigned T_HS_PREP  = 4,
  parameter int unsigned T_HS_ZERO  = 10,
  parameter int unsigned T_HS_TRAIL = 6,
  parameter int unsigned T_HS_EXIT  = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       tx_clock_logic,
  input  logic       rst_n,
  input  logic       start_rqst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic [7:0] hs_byte,
  output logic       hs_tri,
  output logic       lp_p,
  output logic       lp_n,
  output logic       busy,
  output logic       underflow
`ifdef DPHY_LANE_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  udf_cnt
`endif
);

  localparam logic [CNT_W-1:0] LD_LPX   = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] LD_PREP  = CNT_W'(T_HS_PREP - 1);
  localparam logic [CNT_W-1:0] LD_ZERO  = CNT_W'(T_HS_ZERO - 1);
  localparam logic [CNT_W-1:0] LD_TRAIL = CNT_W'(T_HS_TRAIL - 1);
  localparam logic [CNT_W-1:0] LD_EXIT  = CNT_W'(T_HS_EXIT - 1);

  dphy_state_e      state;
  logic             last_bit;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  dphy_lp_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (tx_clock_logic),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer is reloaded on the same edge that enters each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE:     if (start_rqst)  begin tmr_load = 1'b1; tmr_val = LD_LPX;   end
      S_LP01:     if (tmr_zero)    begin tmr_load = 1'b1; tmr_val = LD_PREP;  end
      S_LP00:     if (tmr_zero)    begin tmr_load = 1'b1; tmr_val = LD_ZERO;  end
      S_HS_SYNC,
      S_HS_DATA:  if (!(data_ready && data_valid)) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_TRAIL;
                  end
      S_HS_TRAIL: if (tmr_zero)    begin tmr_load = 1'b1; tmr_val = LD_EXIT;  end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clock_logic or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hs_byte      <= '0;
      hs_tri       <= 1'b1;
      {lp_p, lp_n} <= LP11;
      data_ready   <= 1'b0;
      busy         <= 1'b0;
      underflow    <= 1'b0;
      last_bit     <= 1'b0;
    end else begin
      underflow <= 1'b0;
      case (state)
        S_IDLE: if (start_rqst) begin
          state        <= S_LP01;
          busy         <= 1'b1;
          {lp_p, lp_n} <= LP01;
        end
        S_LP01: if (tmr_zero) begin
          state        <= S_LP00;
          {lp_p, lp_n} <= LP00;
        end
        S_LP00: if (tmr_zero) begin
          state   <= S_HS_ZERO;
          hs_tri  <= 1'b0;
          hs_byte <= '0;
        end
        S_HS_ZERO: if (tmr_zero) begin
          state      <= S_HS_SYNC;
          hs_byte    <= DPHY_SYNC_BYTE;
          data_ready <= 1'b1;
          last_bit   <= 1'b0;
        end
        // data_ready low here means the final byte is on the wire; high with
        // no valid byte is an underrun. Both fall through to the trail.
        S_HS_SYNC, S_HS_DATA: begin
          if (data_ready && data_valid) begin
            state    <= S_HS_DATA;
            hs_byte  <= data_in;
            last_bit <= data_in[7];
            if (data_last) data_ready <= 1'b0;
          end else begin
            state      <= S_HS_TRAIL;
            underflow  <= data_ready;
            data_ready <= 1'b0;
            hs_byte    <= {8{~last_bit}};
          end
        end
        S_HS_TRAIL: if (tmr_zero) begin
          state        <= S_HS_EXIT;
          hs_tri       <= 1'b1;
          hs_byte      <= '0;
          {lp_p, lp_n} <= LP11;
        end
        S_HS_EXIT: if (tmr_zero) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DPHY_LANE_STATS_EN
  always_ff @(posedge tx_clock_logic or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (state == S_HS_EXIT && tmr_zero) pkt_cnt <= pkt_cnt + 16'd1;
      if (underflow && udf_cnt != 8'hFF)  udf_cnt <= udf_cnt + 8'd1;
    end
  end
`endif

endmodule
